// File: rtl/uart_tx_sched.sv
// uart_tx_sched: APB transmit scheduler for the UART engine.
// Bytes written to TXDATA are queued in a circular FIFO and handed to the
// engine one per frame through a tx_start / tx_done handshake. An optional
// idle gap separates frames.
// Handshake: the engine loads tx_data on the cycle tx_start is high. tx_start
// is high for exactly one cycle. tx_data stays stable until the next tx_start.
// tx_done is a one-cycle pulse, honoured only while waiting for a frame to end.
module uart_tx_sched #(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 0
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       PSEL,
  input  logic       PENABLE,
  input  logic       PWRITE,
  input  logic [7:0] PADDR,
  input  logic [7:0] PWDATA,
  output logic [7:0] PRDATA,
  output logic       PREADY,
  output logic       PSLVERR,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_done,
  output logic       irq,
  output logic [1:0] o_state
);

  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW    = AW + 1;
  localparam int GW    = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam int GLOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [GW-1:0] GAP_LOAD  = GW'(GLOAD);
  localparam logic [CW-1:0] COUNT_MAX = CW'(FIFO_DEPTH);

  localparam logic [7:0] ADDR_TXDATA = 8'h00;
  localparam logic [7:0] ADDR_STATUS = 8'h04;
  localparam logic [7:0] ADDR_CTRL   = 8'h08;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_DONE = 2'd1,
    S_GAP       = 2'd2
  } state_t;

  state_t          r_state;
  logic [GW-1:0]   r_gap;
  logic            r_tx_start;
  logic [7:0]      r_tx_data;
  logic            r_irq;
  logic            r_en;
  logic            r_irq_en;
  logic            r_ovf;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  logic            w_access;
  logic            w_sel_txdata;
  logic            w_sel_status;
  logic            w_sel_ctrl;
  logic            w_mapped;
  logic            w_full;
  logic            w_empty;
  logic            w_busy;
  logic            w_push;
  logic            w_pop;
  logic            w_ovf_set;
  logic [3:0]      w_level;

  assign w_access     = PSEL & PENABLE;
  assign w_sel_txdata = (PADDR == ADDR_TXDATA);
  assign w_sel_status = (PADDR == ADDR_STATUS);
  assign w_sel_ctrl   = (PADDR == ADDR_CTRL);
  assign w_mapped     = w_sel_txdata | w_sel_status | w_sel_ctrl;

  assign w_full  = (r_count == COUNT_MAX);
  assign w_empty = (r_count == '0);
  assign w_busy  = (r_state != S_IDLE);
  assign w_level = 4'(r_count);

  // Full is judged on the registered count, so a same-edge pop never rescues a push.
  assign w_push    = w_access & PWRITE & w_sel_txdata & ~w_full;
  assign w_ovf_set = w_access & PWRITE & w_sel_txdata & w_full;
  assign w_pop     = (r_state == S_IDLE) & r_en & ~w_empty;

  assign PREADY   = 1'b1;
  assign PSLVERR  = w_access & (~w_mapped | (PWRITE & w_sel_txdata & w_full));
  assign tx_start = r_tx_start;
  assign tx_data  = r_tx_data;
  assign irq      = r_irq;
  assign o_state  = r_state;

  // Read mux: only drives data during the access phase.
  always_comb begin
    PRDATA = 8'h00;
    if (w_access) begin
      if (w_sel_status) begin
        PRDATA = {w_level, r_ovf, w_busy, w_full, w_empty};
      end else if (w_sel_ctrl) begin
        PRDATA = {6'b0, r_irq_en, r_en};
      end
    end
  end

  // FIFO storage; contents are don't-care while count says empty.
  always_ff @(posedge PCLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= PWDATA;
    end
  end

  // FIFO pointers and occupancy count.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  // Control register and sticky overflow flag.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_en     <= 1'b0;
      r_irq_en <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_access && PWRITE && w_sel_ctrl) begin
        r_en     <= PWDATA[0];
        r_irq_en <= PWDATA[1];
        if (PWDATA[2]) begin
          r_ovf <= 1'b0;
        end
      end
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // Frame scheduler: launch a frame, wait for the engine, then hold the gap.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state    <= S_IDLE;
      r_gap      <= '0;
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'h00;
    end else begin
      r_tx_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_tx_data  <= r_mem[r_rd_ptr];
            r_tx_start <= 1'b1;
            r_state    <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (tx_done) begin
            if (GAP_CYCLES == 0) begin
              r_state <= S_IDLE;
            end else begin
              r_gap   <= GAP_LOAD;
              r_state <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (r_gap == '0) begin
            r_state <= S_IDLE;
          end else begin
            r_gap <= r_gap - GW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Transmit-idle interrupt, registered from the previous edge's state.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= r_irq_en & w_empty & (r_state == S_IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched (FIFO_DEPTH=4, GAP_CYCLES=3).
// Every frame launch is compared against a queue of expected bytes.
module tb_uart_tx_sched;

  localparam int DEPTH = 4;
  localparam int GAP   = 3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam logic [7:0] A_TXDATA = 8'h00;
  localparam logic [7:0] A_STATUS = 8'h04;
  localparam logic [7:0] A_CTRL   = 8'h08;
  localparam logic [7:0] A_BAD    = 8'h0C;

  logic       PCLK;
  logic       PRESETn;
  logic       PSEL;
  logic       PENABLE;
  logic       PWRITE;
  logic [7:0] PADDR;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA;
  logic       PREADY;
  logic       PSLVERR;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_done;
  logic       irq;
  logic [1:0] o_state;

  int         checks;
  int         errors;
  int         start_cnt;
  logic       prev_start;
  logic [7:0] exp_v;
  logic [7:0] exp_q[$];

  uart_tx_sched #(
    .FIFO_DEPTH (DEPTH),
    .GAP_CYCLES (GAP)
  ) dut (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PADDR    (PADDR),
    .PWDATA   (PWDATA),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY),
    .PSLVERR  (PSLVERR),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_done  (tx_done),
    .irq      (irq),
    .o_state  (o_state)
  );

  // clock / reset
  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard: each frame launch pops one expected byte
  initial begin
    start_cnt  = 0;
    prev_start = 1'b0;
  end

  always @(negedge PCLK) begin
    if (tx_start === 1'b1) begin
      start_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_start: got tx_data %02h, expected no frame", tx_data);
      end else begin
        exp_v = exp_q.pop_front();
        if (tx_data !== exp_v) begin
          errors++;
          $display("FAIL sb_tx_data: got %02h expected %02h", tx_data, exp_v);
        end
      end
      checks++;
      if (prev_start !== 1'b0) begin
        errors++;
        $display("FAIL sb_start_consecutive: got tx_start high twice, expected single pulse");
      end
    end
    prev_start = tx_start;
  end

  // driver tasks
  task automatic apb_write(input logic [7:0] addr, input logic [7:0] data, output logic err);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1 err = PSLVERR;
    @(posedge PCLK);
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] addr, output logic [7:0] data, output logic err);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1 begin
      data = PRDATA;
      err  = PSLVERR;
    end
    @(posedge PCLK);
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic tx_done_pulse();
    @(negedge PCLK);
    tx_done = 1'b1;
    @(negedge PCLK);
    tx_done = 1'b0;
  endtask

  // Counts negedges until tx_start is seen; -1 if the budget runs out.
  task automatic wait_start(input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge PCLK);
      if (tx_start === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  // tests
  task automatic test_reset();
    logic [7:0] d;
    logic       e;
    checks++;
    if (PREADY !== 1'b1) begin errors++; $display("FAIL rst_pready: got %b expected 1", PREADY); end
    checks++;
    if (PRDATA !== 8'h00) begin errors++; $display("FAIL rst_prdata: got %02h expected 00", PRDATA); end
    checks++;
    if (PSLVERR !== 1'b0) begin errors++; $display("FAIL rst_pslverr: got %b expected 0", PSLVERR); end
    checks++;
    if (tx_start !== 1'b0) begin errors++; $display("FAIL rst_tx_start: got %b expected 0", tx_start); end
    checks++;
    if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data: got %02h expected 00", tx_data); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b expected 0", irq); end
    checks++;
    if (o_state !== ST_IDLE) begin errors++; $display("FAIL rst_state: got %0d expected %0d", o_state, ST_IDLE); end
    apb_read(A_STATUS, d, e);
    checks++;
    if (d !== 8'h01 || e !== 1'b0) begin errors++; $display("FAIL rst_status: got %02h/%b expected 01/0", d, e); end
    apb_read(A_CTRL, d, e);
    checks++;
    if (d !== 8'h00 || e !== 1'b0) begin errors++; $display("FAIL rst_ctrl: got %02h/%b expected 00/0", d, e); end
  endtask

  task automatic test_single();
    logic [7:0] d;
    logic       e;
    apb_write(A_CTRL, 8'h03, e);
    exp_q.push_back(8'hA5);
    apb_write(A_TXDATA, 8'hA5, e);
    checks++;
    if (e !== 1'b0) begin errors++; $display("FAIL single_push_err: got %b expected 0", e); end
    checks++;
    if (tx_start !== 1'b0) begin errors++; $display("FAIL single_latency_early: got %b expected 0", tx_start); end
    @(negedge PCLK);
    checks++;
    if (tx_start !== 1'b1) begin errors++; $display("FAIL single_latency: got %b expected 1", tx_start); end
    apb_read(A_STATUS, d, e);
    checks++;
    if (d !== 8'h05) begin errors++; $display("FAIL single_status_busy: got %02h expected 05", d); end
    tx_done_pulse();
    checks++;
    if (o_state !== ST_GAP) begin errors++; $display("FAIL single_state_gap: got %0d expected %0d", o_state, ST_GAP); end
    repeat (GAP) @(negedge PCLK);
    checks++;
    if (o_state !== ST_IDLE || irq !== 1'b0) begin
      errors++; $display("FAIL single_idle_irq_lag: got state %0d irq %b expected 0/0", o_state, irq);
    end
    @(negedge PCLK);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL single_irq: got %b expected 1", irq); end
  endtask

  task automatic test_overflow();
    logic [7:0] d;
    logic       e;
    logic [7:0] bytes [5];
    bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    apb_write(A_CTRL, 8'h00, e);
    for (int i = 0; i < 5; i++) begin
      if (i < DEPTH) exp_q.push_back(bytes[i]);
      apb_write(A_TXDATA, bytes[i], e);
      checks++;
      if (e !== ((i < DEPTH) ? 1'b0 : 1'b1)) begin
        errors++; $display("FAIL ovf_pslverr[%0d]: got %b expected %b", i, e, (i >= DEPTH));
      end
    end
    apb_read(A_STATUS, d, e);
    checks++;
    if (d !== 8'h4A) begin errors++; $display("FAIL ovf_status: got %02h expected 4a", d); end
    apb_write(A_CTRL, 8'h04, e);
    apb_read(A_STATUS, d, e);
    checks++;
    if (d !== 8'h42) begin errors++; $display("FAIL ovf_clear: got %02h expected 42", d); end
    apb_read(A_CTRL, d, e);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL ovf_ctrl_read: got %02h expected 00", d); end
  endtask

  task automatic test_gap();
    logic e;
    int   n;
    apb_write(A_CTRL, 8'h01, e);
    wait_start(10, n);
    checks++;
    if (n !== 1) begin errors++; $display("FAIL gap_first_start: got %0d cycles expected 1", n); end
    checks++;
    if (o_state !== ST_WAIT) begin errors++; $display("FAIL gap_wait_state: got %0d expected %0d", o_state, ST_WAIT); end
    tx_done_pulse();
    wait_start(20, n);
    checks++;
    if (n !== GAP + 1) begin errors++; $display("FAIL gap_spacing: got %0d cycles expected %0d", n, GAP + 1); end
  endtask

  task automatic test_en_clear();
    logic [7:0] d;
    logic       e;
    int         s;
    apb_write(A_CTRL, 8'h00, e);
    tx_done_pulse();
    s = start_cnt;
    repeat (10) @(negedge PCLK);
    checks++;
    if (start_cnt !== s) begin errors++; $display("FAIL en_clear_no_start: got %0d starts expected 0", start_cnt - s); end
    checks++;
    if (o_state !== ST_IDLE) begin errors++; $display("FAIL en_clear_idle: got %0d expected %0d", o_state, ST_IDLE); end
    apb_read(A_STATUS, d, e);
    checks++;
    if (d !== 8'h20) begin errors++; $display("FAIL en_clear_status: got %02h expected 20", d); end
    apb_write(A_CTRL, 8'h01, e);
    checks++;
    if (tx_start !== 1'b0) begin errors++; $display("FAIL en_resume_early: got %b expected 0", tx_start); end
    @(negedge PCLK);
    checks++;
    if (tx_start !== 1'b1) begin errors++; $display("FAIL en_resume: got %b expected 1", tx_start); end
  endtask

  task automatic test_unmapped();
    logic [7:0] d;
    logic       e;
    apb_read(A_BAD, d, e);
    checks++;
    if (d !== 8'h00 || e !== 1'b1) begin errors++; $display("FAIL bad_read: got %02h/%b expected 00/1", d, e); end
    apb_write(A_BAD, 8'hFF, e);
    checks++;
    if (e !== 1'b1) begin errors++; $display("FAIL bad_write_err: got %b expected 1", e); end
    apb_read(A_STATUS, d, e);
    checks++;
    if (d !== 8'h14 || e !== 1'b0) begin errors++; $display("FAIL bad_status: got %02h/%b expected 14/0", d, e); end
    apb_read(A_CTRL, d, e);
    checks++;
    if (d !== 8'h01) begin errors++; $display("FAIL bad_ctrl: got %02h expected 01", d); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    logic       e;
    int         s;
    int         n;
    checks++;
    if (o_state !== ST_WAIT || tx_data !== 8'h33) begin
      errors++; $display("FAIL midrst_pre: got state %0d data %02h expected 1/33", o_state, tx_data);
    end
    @(negedge PCLK);
    #2 PRESETn = 1'b0;
    #1;
    checks++;
    if (tx_start !== 1'b0 || tx_data !== 8'h00 || irq !== 1'b0 || o_state !== ST_IDLE ||
        PRDATA !== 8'h00 || PSLVERR !== 1'b0) begin
      errors++;
      $display("FAIL midrst_outputs: got start %b data %02h irq %b state %0d prdata %02h err %b expected all 0",
               tx_start, tx_data, irq, o_state, PRDATA, PSLVERR);
    end
    exp_q.delete();
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;
    s = start_cnt;
    repeat (5) @(negedge PCLK);
    checks++;
    if (start_cnt !== s) begin errors++; $display("FAIL midrst_no_start: got %0d starts expected 0", start_cnt - s); end
    apb_read(A_STATUS, d, e);
    checks++;
    if (d !== 8'h01) begin errors++; $display("FAIL midrst_status: got %02h expected 01", d); end
    apb_read(A_CTRL, d, e);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL midrst_ctrl: got %02h expected 00", d); end
    apb_write(A_CTRL, 8'h01, e);
    exp_q.push_back(8'h5A);
    apb_write(A_TXDATA, 8'h5A, e);
    wait_start(10, n);
    checks++;
    if (n !== 1) begin errors++; $display("FAIL midrst_restart: got %0d cycles expected 1", n); end
    tx_done_pulse();
    repeat (GAP + 2) @(negedge PCLK);
  endtask

  // sequence and final report
  initial begin
    checks  = 0;
    errors  = 0;
    PRESETn = 1'b0;
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    PWRITE  = 1'b0;
    PADDR   = 8'h00;
    PWDATA  = 8'h00;
    tx_done = 1'b0;
    repeat (3) @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);

    test_reset();
    test_single();
    test_overflow();
    test_gap();
    test_en_clear();
    test_unmapped();
    test_reset_mid();

    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL sb_drain: got %0d bytes left expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
